// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one byte-wide memory port between two requesters:
//   port 0 = instruction fetch, port 1 = load/store.
// Every access walks IDLE -> ISSUE -> RESPOND -> RELEASE. Address, write data
// and operation are captured at grant, so requester changes after the grant do
// not disturb the access in flight. Ties are resolved round-robin. After reset
// port 0 wins the first tie.
//
// Ports
//   clk, reset                  single clock, synchronous active-high reset
//   reqN_read / reqN_write      level requests, held until reqN_ready
//   reqN_address                requester address           (ADDR_W)
//   reqN_write_value            requester write data        (DATA_W)
//   reqN_read_value             read data, valid with reqN_ready, held until
//                               the same port's next completion
//   reqN_ready                  one-cycle completion pulse
//   mem_read / mem_write        registered strobes to memory
//   mem_address                 registered address to memory
//   mem_write_value             registered write data to memory
//   mem_read_value              memory read data
//   mem_ready                   memory completion level, drops after strobes drop
//   err                         (ARB_TIMEOUT_EN only) one-cycle watchdog pulse
//
// Build option
//   ARB_TIMEOUT_EN : adds the err output and a 4-bit watchdog. If memory stays
//                    silent for TIMEOUT_CYCLES cycles in ISSUE, the access is
//                    completed with read data 0 and err pulsed with reqN_ready.
//                    Without it, ISSUE waits indefinitely.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_read,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_address,
  input  logic [DATA_W-1:0] req0_write_value,
  output logic [DATA_W-1:0] req0_read_value,
  output logic              req0_ready,
  input  logic              req1_read,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_address,
  input  logic [DATA_W-1:0] req1_write_value,
  output logic [DATA_W-1:0] req1_read_value,
  output logic              req1_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_value,
  input  logic [DATA_W-1:0] mem_read_value,
  input  logic              mem_ready
`ifdef ARB_TIMEOUT_EN
  ,
  output logic              err
`endif
);

  // The watchdog counter is 4 bits wide, so the limit has to fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 16) begin : g_timeout_range
    $error("mem_arbiter: TIMEOUT_CYCLES must be in 1..16");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESPOND = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_q, grant_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_write_value_q, mem_write_value_d;
  logic [DATA_W-1:0] read_value0_q, read_value0_d;
  logic [DATA_W-1:0] read_value1_q, read_value1_d;
  logic              ready0_q, ready0_d;
  logic              ready1_q, ready1_d;
  logic              pend0, pend1;
  logic              pick;

`ifdef ARB_TIMEOUT_EN
  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT_CYCLES - 1);

  logic [3:0] tmo_cnt_q, tmo_cnt_d;
  logic       timed_out_q, timed_out_d;
  logic       err_q, err_d;
`endif

  assign pend0 = req0_read | req0_write;
  assign pend1 = req1_read | req1_write;

  always_comb begin
    state_d           = state_q;
    last_grant_d      = last_grant_q;
    grant_d           = grant_q;
    mem_read_d        = mem_read_q;
    mem_write_d       = mem_write_q;
    mem_address_d     = mem_address_q;
    mem_write_value_d = mem_write_value_q;
    read_value0_d     = read_value0_q;
    read_value1_d     = read_value1_q;
    ready0_d          = 1'b0;
    ready1_d          = 1'b0;
    pick              = 1'b0;
`ifdef ARB_TIMEOUT_EN
    tmo_cnt_d         = tmo_cnt_q;
    timed_out_d       = timed_out_q;
    err_d             = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        // A ready level left over from outside must clear before a new issue,
        // otherwise it would complete the access immediately.
        if ((pend0 || pend1) && !mem_ready) begin
          pick              = (pend0 && pend1) ? ~last_grant_q : pend1;
          grant_d           = pick;
          last_grant_d      = pick;
          mem_address_d     = pick ? req1_address     : req0_address;
          mem_write_value_d = pick ? req1_write_value : req0_write_value;
          // Read wins when a requester raises both.
          mem_read_d        = pick ? req1_read : req0_read;
          mem_write_d       = pick ? (req1_write & ~req1_read)
                                   : (req0_write & ~req0_read);
`ifdef ARB_TIMEOUT_EN
          tmo_cnt_d         = 4'd0;
          timed_out_d       = 1'b0;
`endif
          state_d           = ISSUE;
        end
      end

      ISSUE: begin
        if (mem_ready) begin
          if (grant_q) read_value1_d = mem_read_value;
          else         read_value0_d = mem_read_value;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = RESPOND;
        end
`ifdef ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          if (grant_q) read_value1_d = '0;
          else         read_value0_d = '0;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          timed_out_d = 1'b1;
          state_d     = RESPOND;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 4'd1;
        end
`endif
      end

      RESPOND: begin
        ready0_d = ~grant_q;
        ready1_d = grant_q;
`ifdef ARB_TIMEOUT_EN
        err_d    = timed_out_q;
`endif
        state_d  = RELEASE;
      end

      RELEASE: begin
        if (!mem_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      last_grant_q      <= 1'b1;
      grant_q           <= 1'b0;
      mem_read_q        <= 1'b0;
      mem_write_q       <= 1'b0;
      mem_address_q     <= '0;
      mem_write_value_q <= '0;
      read_value0_q     <= '0;
      read_value1_q     <= '0;
      ready0_q          <= 1'b0;
      ready1_q          <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt_q         <= 4'd0;
      timed_out_q       <= 1'b0;
      err_q             <= 1'b0;
`endif
    end else begin
      state_q           <= state_d;
      last_grant_q      <= last_grant_d;
      grant_q           <= grant_d;
      mem_read_q        <= mem_read_d;
      mem_write_q       <= mem_write_d;
      mem_address_q     <= mem_address_d;
      mem_write_value_q <= mem_write_value_d;
      read_value0_q     <= read_value0_d;
      read_value1_q     <= read_value1_d;
      ready0_q          <= ready0_d;
      ready1_q          <= ready1_d;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt_q         <= tmo_cnt_d;
      timed_out_q       <= timed_out_d;
      err_q             <= err_d;
`endif
    end
  end

  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_address     = mem_address_q;
  assign mem_write_value = mem_write_value_q;
  assign req0_read_value = read_value0_q;
  assign req1_read_value = read_value1_q;
  assign req0_ready      = ready0_q;
  assign req1_ready      = ready1_q;
`ifdef ARB_TIMEOUT_EN
  assign err             = err_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. A behavioural memory device answers the
// arbiter (configurable wait states, lingering ready, externally forced ready,
// or silence). Expected read data comes from a transaction-level model of the
// memory contents, updated when each write completes; grant order comes from
// the round-robin rule applied to observed completions.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int ADDR_W         = 8;
  localparam int DATA_W         = 8;
  localparam int TIMEOUT_CYCLES = 15;

  logic              clk              = 1'b0;
  logic              reset            = 1'b1;
  logic              req0_read        = 1'b0;
  logic              req0_write       = 1'b0;
  logic [ADDR_W-1:0] req0_address     = '0;
  logic [DATA_W-1:0] req0_write_value = '0;
  logic [DATA_W-1:0] req0_read_value;
  logic              req0_ready;
  logic              req1_read        = 1'b0;
  logic              req1_write       = 1'b0;
  logic [ADDR_W-1:0] req1_address     = '0;
  logic [DATA_W-1:0] req1_write_value = '0;
  logic [DATA_W-1:0] req1_read_value;
  logic              req1_ready;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_value;
  logic [DATA_W-1:0] mem_read_value   = '0;
  logic              mem_ready;
`ifdef ARB_TIMEOUT_EN
  logic              err;
`endif

  mem_arbiter #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req0_read        (req0_read),
    .req0_write       (req0_write),
    .req0_address     (req0_address),
    .req0_write_value (req0_write_value),
    .req0_read_value  (req0_read_value),
    .req0_ready       (req0_ready),
    .req1_read        (req1_read),
    .req1_write       (req1_write),
    .req1_address     (req1_address),
    .req1_write_value (req1_write_value),
    .req1_read_value  (req1_read_value),
    .req1_ready       (req1_ready),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_address      (mem_address),
    .mem_write_value  (mem_write_value),
    .mem_read_value   (mem_read_value),
    .mem_ready        (mem_ready)
`ifdef ARB_TIMEOUT_EN
    ,
    .err              (err)
`endif
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checking
  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return a ^ 8'h4A;
  endfunction

  // ------------------------------------------------------- memory device
  logic [7:0] mem_arr [256];
  bit   mem_init  = 1'b1;
  bit   rand_mode = 1'b0;
  bit   never_rdy = 1'b0;
  bit   ext_rdy   = 1'b0;
  logic rdy_r     = 1'b0;
  int   wait_cfg  = 0;
  int   stale_cfg = 0;
  int   wcnt      = 0;
  int   stale_cnt = 0;

  assign mem_ready = rdy_r | ext_rdy;

  // Ready rises wait_cfg+1 edges after the strobe is first seen and falls
  // stale_cfg+1 edges after the strobe goes away.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= init_val(8'(i));
      rdy_r     <= 1'b0;
      wcnt      <= 0;
      stale_cnt <= 0;
    end else if (mem_read || mem_write) begin
      stale_cnt <= 0;
      if (!rdy_r) begin
        if (!never_rdy && (rand_mode ? ($urandom_range(0, 1) == 0) : (wcnt >= wait_cfg))) begin
          rdy_r          <= 1'b1;
          mem_read_value <= mem_arr[mem_address];
          if (mem_write) mem_arr[mem_address] <= mem_write_value;
        end else begin
          wcnt <= wcnt + 1;
        end
      end
    end else begin
      wcnt <= 0;
      if (rdy_r) begin
        if (rand_mode ? ($urandom_range(0, 2) == 0) : (stale_cnt >= stale_cfg)) rdy_r <= 1'b0;
        else stale_cnt <= stale_cnt + 1;
      end
    end
  end

  // ------------------------------------------------------- reference model
  logic [7:0] model [256];
  int         last_port = 1;   // port 0 wins the first tie after reset
  int         done_cnt [2];

  // One access on port p: drive, wait (bounded) for the completion pulse,
  // compare against the model, then drop the request.
  task automatic xact(input int p, input bit rd, input bit wr,
                      input logic [7:0] a, input logic [7:0] d, input string tag,
                      output int lat, output bit s_rd, output bit s_wr,
                      output logic [7:0] s_a, output logic [7:0] s_wv, output int other);
    bit         got;
    int         start_other;
    logic [7:0] rv;
    start_other = done_cnt[1-p];
    if (p == 0) begin
      req0_read = rd; req0_write = wr; req0_address = a; req0_write_value = d;
    end else begin
      req1_read = rd; req1_write = wr; req1_address = a; req1_write_value = d;
    end
    lat = 0; got = 1'b0; other = 0;
    s_rd = 1'b0; s_wr = 1'b0; s_a = '0; s_wv = '0;
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        s_rd = mem_read; s_wr = mem_write; s_a = mem_address; s_wv = mem_write_value;
      end
      if ((p == 0) ? req1_ready : req0_ready) other++;
      got = (p == 0) ? req0_ready : req1_ready;
    end
    if (p == 0) begin req0_read = 1'b0; req0_write = 1'b0; end
    else        begin req1_read = 1'b0; req1_write = 1'b0; end
    check({tag, "_done"}, 32'(got), 32'd1);
    if (got) begin
      rv = (p == 0) ? req0_read_value : req1_read_value;
      if (rd) check({tag, "_rdata"}, 32'(rv), 32'(model[a]));
      else    model[a] = d;
      done_cnt[p]++;
      check({tag, "_fair"}, 32'(done_cnt[1-p] - start_other <= 1), 32'd1);
      last_port = p;
    end
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (mem_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) check("idle_wait", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // Both ports request continuously; completions must alternate.
  task automatic contend(input int n, input string tag);
    int exp_p, got_p, nseen, cyc;
    req0_read = 1'b1; req0_address = 8'h01;
    req1_read = 1'b1; req1_address = 8'h02;
    exp_p = 1 - last_port; nseen = 0; cyc = 0;
    while (nseen < n && cyc < 40 * n) begin
      @(negedge clk);
      cyc++;
      if (req0_ready || req1_ready) begin
        got_p = req1_ready ? 1 : 0;
        check({tag, "_order"}, 32'(got_p), 32'(exp_p));
        check({tag, "_single"}, 32'(req0_ready & req1_ready), 32'd0);
        check({tag, "_rdata"}, 32'(got_p ? req1_read_value : req0_read_value),
              32'(got_p ? model[2] : model[1]));
        last_port = got_p;
        exp_p     = 1 - got_p;
        nseen++;
      end
    end
    req0_read = 1'b0; req1_read = 1'b0;
    check({tag, "_count"}, 32'(nseen), 32'(n));
  endtask

  task automatic requester(input int p, input int n);
    int         lat, oth, idle;
    bit         rd, wr, s_rd, s_wr;
    logic [7:0] a, d, s_a, s_wv;
    for (int k = 0; k < n; k++) begin
      idle = $urandom_range(0, 3);
      repeat (idle) @(negedge clk);
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) wr = 1'b1;
      a  = 8'h40 + 8'($urandom_range(0, 7));
      d  = 8'($urandom);
      xact(p, rd, wr, a, d, (p == 0) ? "rnd0" : "rnd1", lat, s_rd, s_wr, s_a, s_wv, oth);
    end
  endtask

  // ------------------------------------------------------------- stimulus
  initial begin
    int         lat, oth, pulses, cyc;
    bit         s_rd, s_wr, released;
    logic [7:0] s_a, s_wv;

    for (int i = 0; i < 256; i++) model[i] = init_val(8'(i));

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mem_read",  32'(mem_read),        32'd0);
    check("rst_mem_write", 32'(mem_write),       32'd0);
    check("rst_mem_addr",  32'(mem_address),     32'd0);
    check("rst_mem_wv",    32'(mem_write_value), 32'd0);
    check("rst_ready0",    32'(req0_ready),      32'd0);
    check("rst_ready1",    32'(req1_ready),      32'd0);
    check("rst_rval0",     32'(req0_read_value), 32'd0);
    check("rst_rval1",     32'(req1_read_value), 32'd0);
    reset = 1'b0; mem_init = 1'b0;
    @(negedge clk);

    // Single read, zero-wait memory: strobe on the first sample after the
    // grant edge, completion three cycles after the grant.
    xact(0, 1'b1, 1'b0, 8'h10, 8'h00, "rd1", lat, s_rd, s_wr, s_a, s_wv, oth);
    check("rd1_strobe", 32'(s_rd), 32'd1);
    check("rd1_nowr",   32'(s_wr), 32'd0);
    check("rd1_addr",   32'(s_a),  32'h10);
    check("rd1_lat",    32'(lat),  32'(1 + 3));
    check("rd1_other",  32'(oth),  32'd0);
    check("rd1_value",  32'(req0_read_value), 32'h5A);
    wait_idle();

    // Write then read back on port 1
    xact(1, 1'b0, 1'b1, 8'h22, 8'hC3, "wr1", lat, s_rd, s_wr, s_a, s_wv, oth);
    check("wr1_strobe", 32'(s_wr), 32'd1);
    check("wr1_nord",   32'(s_rd), 32'd0);
    check("wr1_addr",   32'(s_a),  32'h22);
    check("wr1_wv",     32'(s_wv), 32'hC3);
    check("wr1_lat",    32'(lat),  32'(1 + 3));
    check("wr1_other",  32'(oth),  32'd0);
    wait_idle();
    xact(1, 1'b1, 1'b0, 8'h22, 8'h00, "rd2", lat, s_rd, s_wr, s_a, s_wv, oth);
    check("rd2_value",  32'(req1_read_value), 32'hC3);
    check("rd2_rval0_held", 32'(req0_read_value), 32'h5A);
    wait_idle();

    // Read and write raised together: treated as a read
    xact(0, 1'b1, 1'b1, 8'h22, 8'h77, "rdwr", lat, s_rd, s_wr, s_a, s_wv, oth);
    check("rdwr_strobe_rd", 32'(s_rd), 32'd1);
    check("rdwr_strobe_wr", 32'(s_wr), 32'd0);
    wait_idle();

    // Contention
    contend(6, "cont");
    wait_idle();

    // Lingering ready after the strobe drops: no re-issue while it is high
    stale_cfg = 3;
    req0_read = 1'b1; req0_address = 8'h30;
    pulses = 0; released = 1'b0; cyc = 0;
    while (!released && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (req0_ready) begin
        pulses++;
        check("stale_rdata", 32'(req0_read_value), 32'(model[8'h30]));
      end else if (pulses > 0) begin
        if (mem_ready) check("stale_no_reissue", 32'({mem_read, mem_write}), 32'd0);
        else released = 1'b1;
      end
    end
    req0_read = 1'b0;
    check("stale_released", 32'(released), 32'd1);
    check("stale_pulses",   32'(pulses),   32'd1);
    last_port = 0;
    done_cnt[0]++;
    stale_cfg = 0;
    wait_idle();

    // Ready already high in IDLE: nothing issues until it clears
    ext_rdy = 1'b1;
    req1_read = 1'b1; req1_address = 8'h55;
    repeat (5) begin
      @(negedge clk);
      check("ext_rdy_no_issue", 32'({mem_read, req1_ready}), 32'd0);
    end
    req1_read = 1'b0; ext_rdy = 1'b0;
    wait_idle();
    xact(1, 1'b1, 1'b0, 8'h55, 8'h00, "ext_after", lat, s_rd, s_wr, s_a, s_wv, oth);
    wait_idle();

    // Reset in the middle of an access
    wait_cfg = 5;
    req0_read = 1'b1; req0_address = 8'h10;
    repeat (2) @(negedge clk);
    check("rstmid_in_issue", 32'(mem_read), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_mem_read", 32'(mem_read),   32'd0);
    check("rstmid_ready0",   32'(req0_ready), 32'd0);
    check("rstmid_ready1",   32'(req1_ready), 32'd0);
    reset = 1'b0; req0_read = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (req0_ready || req1_ready) pulses++;
    end
    check("rstmid_no_cmpl", 32'(pulses), 32'd0);
    last_port = 1;
    wait_cfg = 0;
    wait_idle();

    // First tie after reset goes to port 0
    contend(2, "tie");
    wait_idle();

`ifdef ARB_TIMEOUT_EN
    // Silent memory: watchdog completes the access with zero data
    never_rdy = 1'b1;
    req0_read = 1'b1; req0_address = 8'h10;
    lat = 0; pulses = 0; released = 1'b0;
    while (!released && lat < 60) begin
      @(negedge clk);
      lat++;
      if (err) pulses++;
      released = req0_ready;
    end
    check("tmo_ready",    32'(released),        32'd1);
    check("tmo_lat",      32'(lat),             32'(1 + TIMEOUT_CYCLES + 1));
    check("tmo_err",      32'(err),             32'd1);
    check("tmo_rval",     32'(req0_read_value), 32'd0);
    check("tmo_mem_read", 32'(mem_read),        32'd0);
    req0_read = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (err) pulses++;
    end
    check("tmo_err_once", 32'(pulses), 32'd1);
    last_port = 0;
    never_rdy = 1'b0;
    wait_idle();
`endif

    // Randomized traffic from both ports with a random-latency memory
    rand_mode = 1'b1;
    fork
      requester(0, 30);
      requester(1, 30);
    join
    rand_mode = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
